user_db_arbiter: RTL and testbench

//  Sequences and shares the single-port user-record SRAM (SYNCSRAM: password, admin, lock and wrong-try count per
//  3-digit BCD username) between two requesters: port 0 = login FSM, port 1 = admin panel.

---
 rtl/user_db_pkg.sv | 37 +++
 rtl/user_db_arbiter_rr_arb2.sv | 37 +++
 rtl/user_db_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_user_db_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/user_db_pkg.sv
// Shared encodings, widths and helpers for the user-record SRAM arbiter.
package user_db_pkg;

  localparam int ADDR_W = 12;
  localparam int PASS_W = 16;
  localparam int CNT_W  = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WR_PASS = 2'b01,
    OP_LOCK    = 2'b10,
    OP_FAIL    = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_UPD   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // A username is three BCD digits; any nibble above 9 is not a valid user.
  function automatic logic bcd_addr_ok(input logic [ADDR_W-1:0] a);
    return (a[11:8] <= BCD_MAX) && (a[7:4] <= BCD_MAX) && (a[3:0] <= BCD_MAX);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == 4'hF) begin
      return 4'hF;
    end else begin
      return c + 4'd1;
    end
  endfunction

endpackage

// File: rtl/user_db_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; after reset port 0 is preferred.
module rr_arb2
  import user_db_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // last_r = 1 means port 1 was served last, so port 0 wins a tie
  logic last_r;

  // Grant selection from current requests and last-served port
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember which port took the grant
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_r <= 1'b1;
    end else if (advance && (|gnt)) begin
      last_r <= gnt[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/user_db_arbiter.sv
// Shares the single-port user-record SRAM between the login FSM (port 0) and the
// admin panel (port 1), expanding each high-level op into cs/rw sequences.
module user_db_arbiter
  import user_db_pkg::*;
#(
  parameter int MAX_TRIES = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic        locked,
  output logic [15:0] rd_pass,
  output logic        rd_admin,
  output logic [3:0]  rd_count,
  output logic        busy,
  output logic        ram_cs,
  output logic        ram_pass_rw,
  output logic        ram_admin_rw,
  output logic        ram_lock_rw,
  output logic        ram_count_rw,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_pass_in,
  output logic [3:0]  ram_count_in,
  output logic        ram_admin_in,
  output logic        ram_lock_in,
  input  logic [15:0] ram_pass_out,
  input  logic [3:0]  ram_count_out,
  input  logic        ram_admin_out,
  input  logic        ram_lock_out
);

  state_t             state_r, next_s;
  op_t                op_r, op_sel_s;
  logic               owner_r, owner_s;
  logic [1:0]         gnt_s;
  logic [ADDR_W-1:0]  addr_sel_s;
  logic [PASS_W-1:0]  wdata_sel_s;
  logic [CNT_W-1:0]   inc_s;
  logic               hit_max_s;

  logic               nx_cs_s, nx_pass_rw_s, nx_lock_rw_s, nx_count_rw_s, nx_lock_in_s;
  logic [PASS_W-1:0]  nx_pass_in_s;
  logic [CNT_W-1:0]   nx_count_in_s;

  rr_arb2 u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     ({req1, req0}),
    .advance (state_r == ST_IDLE),
    .gnt     (gnt_s)
  );

  assign op_sel_s    = op_t'(gnt_s[1] ? op1 : op0);
  assign addr_sel_s  = gnt_s[1] ? addr1 : addr0;
  assign wdata_sel_s = gnt_s[1] ? wdata1 : wdata0;
  assign owner_s     = (state_r == ST_IDLE) ? gnt_s[1] : owner_r;

  // Wrong-try update is computed from the freshly read count (valid in CAPT)
  assign inc_s     = sat_inc(ram_count_out);
  assign hit_max_s = ({1'b0, ram_count_out} + 5'd1) >= 5'(MAX_TRIES);

  // The admin bit is never rewritten by any op
  assign ram_admin_rw = 1'b0;
  assign ram_admin_in = 1'b0;

  // Next state and the SRAM strobes to present during the next state
  always_comb begin
    next_s        = state_r;
    nx_cs_s       = 1'b0;
    nx_pass_rw_s  = 1'b0;
    nx_lock_rw_s  = 1'b0;
    nx_count_rw_s = 1'b0;
    nx_lock_in_s  = 1'b0;
    nx_pass_in_s  = 16'h0000;
    nx_count_in_s = 4'h0;
    case (state_r)
      ST_IDLE: begin
        if (|gnt_s) begin
          if (!bcd_addr_ok(addr_sel_s)) begin
            next_s = ST_RESP;
          end else begin
            next_s  = ST_ISSUE;
            nx_cs_s = 1'b1;
            if (op_sel_s == OP_WR_PASS) begin
              nx_pass_rw_s  = 1'b1;
              nx_count_rw_s = 1'b1;
              nx_lock_rw_s  = 1'b1;
              nx_pass_in_s  = wdata_sel_s;
            end else begin
              nx_pass_rw_s = 1'b0;
            end
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_s = (op_r == OP_WR_PASS) ? ST_RESP : ST_CAPT;
      ST_CAPT: begin
        case (op_r)
          OP_FAIL: begin
            next_s        = ST_UPD;
            nx_cs_s       = 1'b1;
            nx_count_rw_s = 1'b1;
            nx_count_in_s = inc_s;
            nx_lock_rw_s  = hit_max_s;
            nx_lock_in_s  = hit_max_s;
          end
          OP_LOCK: begin
            if (ram_admin_out) begin
              next_s = ST_RESP;
            end else begin
              next_s       = ST_UPD;
              nx_cs_s      = 1'b1;
              nx_lock_rw_s = 1'b1;
              nx_lock_in_s = 1'b1;
            end
          end
          default: next_s = ST_RESP;
        endcase
      end
      ST_UPD:  next_s = ST_RESP;
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State register and registered strobes/handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      ram_cs       <= 1'b0;
      ram_pass_rw  <= 1'b0;
      ram_lock_rw  <= 1'b0;
      ram_count_rw <= 1'b0;
      ram_lock_in  <= 1'b0;
      ram_pass_in  <= 16'h0000;
      ram_count_in <= 4'h0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= next_s;
      ram_cs       <= nx_cs_s;
      ram_pass_rw  <= nx_pass_rw_s;
      ram_lock_rw  <= nx_lock_rw_s;
      ram_count_rw <= nx_count_rw_s;
      ram_lock_in  <= nx_lock_in_s;
      ram_pass_in  <= nx_pass_in_s;
      ram_count_in <= nx_count_in_s;
      done0        <= (next_s == ST_RESP) && !owner_s;
      done1        <= (next_s == ST_RESP) && owner_s;
      busy         <= (next_s != ST_IDLE);
    end
  end

  // Request latch at grant and result capture; results hold between ops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_r  <= 1'b0;
      op_r     <= OP_READ;
      ram_addr <= 12'h000;
      err      <= 1'b0;
      locked   <= 1'b0;
      rd_pass  <= 16'h0000;
      rd_admin <= 1'b0;
      rd_count <= 4'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|gnt_s) begin
            owner_r  <= gnt_s[1];
            op_r     <= op_sel_s;
            ram_addr <= addr_sel_s;
            err      <= !bcd_addr_ok(addr_sel_s);
            locked   <= 1'b0;
          end else begin
            owner_r <= owner_r;
          end
        end
        ST_CAPT: begin
          rd_pass  <= ram_pass_out;
          rd_admin <= ram_admin_out;
          // FAIL/LOCK report the values the UPD access is about to write
          case (op_r)
            OP_FAIL: begin
              rd_count <= inc_s;
              locked   <= ram_lock_out | hit_max_s;
            end
            OP_LOCK: begin
              rd_count <= ram_count_out;
              locked   <= ram_admin_out ? ram_lock_out : 1'b1;
              err      <= ram_admin_out;
            end
            default: begin
              rd_count <= ram_count_out;
              locked   <= ram_lock_out;
            end
          endcase
        end
        default: owner_r <= owner_r;
      endcase
    end
  end

endmodule

// File: tb/tb_user_db_arbiter.sv
// Directed bench for user_db_arbiter with a behavioural single-port SRAM (1-cycle read latency).
module tb_user_db_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  op0 = 2'b00, op1 = 2'b00;
  logic [11:0] addr0 = 12'h000, addr1 = 12'h000;
  logic [15:0] wdata0 = 16'h0000, wdata1 = 16'h0000;
  logic        done0, done1, err, locked, rd_admin, busy;
  logic [15:0] rd_pass;
  logic [3:0]  rd_count;
  logic        ram_cs, ram_pass_rw, ram_admin_rw, ram_lock_rw, ram_count_rw;
  logic [11:0] ram_addr;
  logic [15:0] ram_pass_in;
  logic [3:0]  ram_count_in;
  logic        ram_admin_in, ram_lock_in;
  logic [15:0] ram_pass_out = 16'h0000;
  logic [3:0]  ram_count_out = 4'h0;
  logic        ram_admin_out = 1'b0, ram_lock_out = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cs_cnt = 0, wr_cnt = 0, lockwr_cnt = 0, done0_cnt = 0, done1_cnt = 0;

  localparam logic [1:0] RD = 2'b00, WP = 2'b01, LK = 2'b10, FL = 2'b11;

  logic [15:0] pass_mem  [0:4095];
  logic        admin_mem [0:4095];
  logic        lock_mem  [0:4095];
  logic [3:0]  count_mem [0:4095];

  user_db_arbiter #(.MAX_TRIES(3)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err(err), .locked(locked), .rd_pass(rd_pass),
    .rd_admin(rd_admin), .rd_count(rd_count), .busy(busy), .ram_cs(ram_cs),
    .ram_pass_rw(ram_pass_rw), .ram_admin_rw(ram_admin_rw), .ram_lock_rw(ram_lock_rw),
    .ram_count_rw(ram_count_rw), .ram_addr(ram_addr), .ram_pass_in(ram_pass_in),
    .ram_count_in(ram_count_in), .ram_admin_in(ram_admin_in), .ram_lock_in(ram_lock_in),
    .ram_pass_out(ram_pass_out), .ram_count_out(ram_count_out),
    .ram_admin_out(ram_admin_out), .ram_lock_out(ram_lock_out)
  );

  always #5 CLK = ~CLK;

  // SRAM model: per-field write or registered read on each cs cycle
  always @(posedge CLK) begin
    if (ram_cs) begin
      if (ram_pass_rw)  pass_mem[ram_addr]  <= ram_pass_in;  else ram_pass_out  <= pass_mem[ram_addr];
      if (ram_admin_rw) admin_mem[ram_addr] <= ram_admin_in; else ram_admin_out <= admin_mem[ram_addr];
      if (ram_lock_rw)  lock_mem[ram_addr]  <= ram_lock_in;  else ram_lock_out  <= lock_mem[ram_addr];
      if (ram_count_rw) count_mem[ram_addr] <= ram_count_in; else ram_count_out <= count_mem[ram_addr];
    end
  end

  always @(posedge CLK) begin
    if (ram_cs) cs_cnt++;
    if (ram_cs && (ram_pass_rw || ram_admin_rw || ram_lock_rw || ram_count_rw)) wr_cnt++;
    if (ram_cs && ram_lock_rw && ram_lock_in) lockwr_cnt++;
    if (done0) done0_cnt++;
    if (done1) done1_cnt++;
  end

  task automatic clear_mon();
    cs_cnt = 0; wr_cnt = 0; lockwr_cnt = 0; done0_cnt = 0; done1_cnt = 0;
  endtask

  // Start from an idle cycle, issue one op, return #1 after the done edge (lat = -1 on timeout)
  task automatic do_op(input bit port, input logic [1:0] op, input logic [11:0] a,
                       input logic [15:0] wd, output int lat);
    bit got = 1'b0;
    @(posedge CLK); #1;
    if (!port) begin req0 = 1'b1; op0 = op; addr0 = a; wdata0 = wd; end
    else       begin req1 = 1'b1; op1 = op; addr1 = a; wdata1 = wd; end
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (port ? done1 : done0) got = 1'b1;
    end
    if (!got) lat = -1;
    if (!port) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [71:0] outs;
    repeat (3) @(posedge CLK);
    #1;
    outs = {done0, done1, err, locked, rd_pass, rd_admin, rd_count, busy, ram_cs, ram_pass_rw,
            ram_admin_rw, ram_lock_rw, ram_count_rw, ram_addr, ram_pass_in, ram_count_in,
            ram_admin_in, ram_lock_in};
    n_checks++;
    if (outs !== 72'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_read();
    int lat;
    clear_mon();
    do_op(1'b0, RD, 12'h123, 16'h0000, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d expected 3", lat); end
    n_checks++; if (rd_pass !== 16'h4567) begin n_fail++; $display("FAIL read_pass: got %h expected 4567", rd_pass); end
    n_checks++; if ({err, rd_admin, done1, busy} !== 4'b0001) begin n_fail++; $display("FAIL read_flags: got %b expected 0001", {err, rd_admin, done1, busy}); end
    n_checks++; if (cs_cnt !== 1) begin n_fail++; $display("FAIL read_cs_pulses: got %0d expected 1", cs_cnt); end
    @(posedge CLK); #1;
    n_checks++; if ({busy, done0, rd_pass} !== {2'b00, 16'h4567}) begin n_fail++; $display("FAIL read_after: got %h expected 04567", {busy, done0, rd_pass}); end
  endtask

  task automatic test_lock_admin();
    int lat;
    clear_mon();
    do_op(1'b1, LK, 12'h001, 16'h0000, lat);
    n_checks++; if ({err, rd_admin} !== 2'b11) begin n_fail++; $display("FAIL lock_admin_err: got %b expected 11", {err, rd_admin}); end
    n_checks++; if (lat < 0) begin n_fail++; $display("FAIL lock_admin_done: got timeout expected done1"); end
    repeat (3) @(posedge CLK); #1;
    n_checks++; if ({wr_cnt, cs_cnt, done0_cnt} !== {32'd0, 32'd1, 32'd0}) begin n_fail++; $display("FAIL lock_admin_strobes: wr %0d cs %0d done0 %0d expected 0 1 0", wr_cnt, cs_cnt, done0_cnt); end
  endtask

  task automatic test_contention();
    int lat = -1, gap = -1;
    clear_mon();
    @(posedge CLK); #1;
    req0 = 1'b1; op0 = FL; addr0 = 12'h123;
    req1 = 1'b1; op1 = RD; addr1 = 12'h123;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge CLK); #1;
      if (done0) lat = i;
    end
    req0 = 1'b0;
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL contend_port0_first: got %0d expected 4", lat); end
    n_checks++; if (done1_cnt !== 0) begin n_fail++; $display("FAIL contend_port1_early: got %0d expected 0", done1_cnt); end
    for (int i = 1; i <= 20 && gap < 0; i++) begin
      @(posedge CLK); #1;
      if (done1) gap = i;
    end
    req1 = 1'b0;
    n_checks++; if (gap !== 4) begin n_fail++; $display("FAIL contend_port1_gap: got %0d expected 4", gap); end
    n_checks++; if ({rd_count, rd_pass, err} !== {4'd1, 16'h4567, 1'b0}) begin n_fail++; $display("FAIL contend_port1_data: got %h expected 145670", {rd_count, rd_pass, err}); end
    // port 1 was served last, so a new tie goes to port 0
    clear_mon();
    @(posedge CLK); #1;
    req0 = 1'b1; op0 = RD; addr0 = 12'h123;
    req1 = 1'b1; op1 = RD; addr1 = 12'h200;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge CLK); #1;
      if (done0 || done1) lat = i;
    end
    n_checks++; if ({done0, done1} !== 2'b10) begin n_fail++; $display("FAIL contend_pointer_flip: got %b expected 10", {done0, done1}); end
    req0 = 1'b0;
    for (int i = 0; i < 20 && done1_cnt == 0; i++) @(posedge CLK);
    #1;
    req1 = 1'b0;
  endtask

  task automatic test_fail_lock();
    int lat;
    for (int k = 1; k <= 4; k++) begin
      clear_mon();
      do_op(1'b0, FL, 12'h200, 16'h0000, lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL fail_latency_%0d: got %0d expected 4", k, lat); end
      n_checks++; if ({rd_count, locked, err} !== {4'(k), (k >= 3), 1'b0}) begin n_fail++; $display("FAIL fail_count_%0d: got %h expected %h", k, {rd_count, locked, err}, {4'(k), (k >= 3), 1'b0}); end
      n_checks++; if (lockwr_cnt !== ((k >= 3) ? 1 : 0)) begin n_fail++; $display("FAIL fail_lock_write_%0d: got %0d expected %0d", k, lockwr_cnt, (k >= 3) ? 1 : 0); end
    end
  endtask

  task automatic test_wr_pass();
    int lat;
    clear_mon();
    do_op(1'b0, WP, 12'h200, 16'h9999, lat);
    n_checks++; if ({lat, err} !== {32'd2, 1'b0}) begin n_fail++; $display("FAIL wrpass_done: lat %0d err %b expected 2 0", lat, err); end
    n_checks++; if ({cs_cnt, wr_cnt} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL wrpass_strobes: cs %0d wr %0d expected 1 1", cs_cnt, wr_cnt); end
    do_op(1'b0, RD, 12'h200, 16'h0000, lat);
    n_checks++; if ({rd_pass, rd_count, locked} !== {16'h9999, 4'd0, 1'b0}) begin n_fail++; $display("FAIL wrpass_readback: got %h expected 999900", {rd_pass, rd_count, locked}); end
    clear_mon();
    do_op(1'b1, RD, 12'h1A3, 16'h0000, lat);
    n_checks++; if ({lat, err} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL bad_addr: lat %0d err %b expected 1 1", lat, err); end
    n_checks++; if (cs_cnt !== 0) begin n_fail++; $display("FAIL bad_addr_cs: got %0d expected 0", cs_cnt); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    @(posedge CLK); #1;
    clear_mon();
    req0 = 1'b1; op0 = FL; addr0 = 12'h123;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    n_checks++; if ({busy, ram_cs, done0, ram_count_rw, ram_lock_rw} !== 5'b0) begin n_fail++; $display("FAIL midreset_outputs: got %b expected 00000", {busy, ram_cs, done0, ram_count_rw, ram_lock_rw}); end
    req0 = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    n_checks++; if ({done0_cnt, cs_cnt, wr_cnt} !== {32'd0, 32'd1, 32'd0}) begin n_fail++; $display("FAIL midreset_abort: done %0d cs %0d wr %0d expected 0 1 0", done0_cnt, cs_cnt, wr_cnt); end
    do_op(1'b0, RD, 12'h123, 16'h0000, lat);
    n_checks++; if ({lat, rd_count} !== {32'd3, 4'd1}) begin n_fail++; $display("FAIL midreset_next: lat %0d count %0d expected 3 1", lat, rd_count); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      pass_mem[i] = 16'h0000; admin_mem[i] = 1'b0; lock_mem[i] = 1'b0; count_mem[i] = 4'h0;
    end
    pass_mem[12'h123] = 16'h4567;
    pass_mem[12'h200] = 16'h1111;
    pass_mem[12'h001] = 16'hAAAA;
    admin_mem[12'h001] = 1'b1;
    test_reset();
    test_read();
    test_lock_admin();
    test_contention();
    test_fail_lock();
    test_wr_pass();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
